hs_rate_monitor: RTL

- Measurement stage downstream of the HOG core and the bus switch handshake taps.
- Samples valid/ready pairs every clock and accumulates per-window counts: transfer beats, stall cycles and backpressure cycles.
- At the end of each fixed window it publishes the counts as 32-bit words for the lw-bridge PIOs, giving software a throughput readout (beats/s) alongside the raw status bits.

---
 rtl/hs_rate_monitor_pkg.sv | 20 ++
 rtl/hs_rate_monitor_sat_counter32.sv | 36 +++
 rtl/hs_rate_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hs_rate_monitor_pkg.sv
// Shared constants for the handshake rate monitor: state encoding,
// PIO word width, saturating counter width and window length derivation.
package hs_rate_monitor_pkg;

   localparam int PIO_W = 32;
   localparam int SAT_W = 32;
   localparam int N_CNT = 5;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_COUNT = 1'b1;

   // Window length in clocks; never shorter than one cycle.
   function automatic int window_cycles(input int clock_freq, input int window_freq);
      int wc;
      wc = clock_freq / window_freq;
      if (wc < 1) wc = 1;
      return wc;
   endfunction

endpackage

// File: rtl/hs_rate_monitor_sat_counter32.sv
// Saturating event accumulator. load_zero restarts the count at the window
// boundary; count_inc is the value including this cycle's event, which the
// parent publishes on the terminal cycle so no beat is lost across windows.
module sat_counter32
   import hs_rate_monitor_pkg::*;
#(
   parameter int W = SAT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load_zero,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic [W-1:0] count_inc
);

   logic [W-1:0] r_count;
   logic         w_full;

   assign w_full    = &r_count;
   assign count_inc = (inc && !w_full) ? r_count + W'(1) : r_count;
   assign count     = r_count;

   // Accumulate, saturating at all-ones; clear or window restart zeroes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear || load_zero) begin
         r_count <= '0;
      end else begin
         r_count <= count_inc;
      end
   end

endmodule

// File: rtl/hs_rate_monitor.sv
// Handshake rate monitor: counts transfer beats, stalls and backpressure
// per fixed window and publishes them as 32-bit PIO words with a strobe.
module hs_rate_monitor
   import hs_rate_monitor_pkg::*;
#(
   parameter int CLOCK_FREQ  = 50_000_000,
   parameter int WINDOW_FREQ = 1,
   parameter int LEVELS      = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clear,
   input  logic              hog_input_valid,
   input  logic              hog_input_ready,
   input  logic [LEVELS-1:0] hog_out_valid,
   input  logic [LEVELS-1:0] hog_out_ready,
   input  logic              switch_out_valid,
   input  logic              switch_out_ready,
   output logic [PIO_W-1:0]  in_beats_pio,
   output logic [PIO_W-1:0]  in_stall_pio,
   output logic [PIO_W-1:0]  out_beats_pio,
   output logic [PIO_W-1:0]  out_bp_pio,
   output logic [PIO_W-1:0]  switch_beats_pio,
   output logic [PIO_W-1:0]  window_id_pio,
   output logic              snap_pulse,
   output logic [0:0]        dbg_state
);

   // Handshake rule observed on every tap: a beat is a cycle with valid and
   // ready both high; valid without ready is a stall/backpressure cycle.

   localparam int               WINDOW_CYCLES = window_cycles(CLOCK_FREQ, WINDOW_FREQ);
   localparam logic [PIO_W-1:0] TERM_CNT      = PIO_W'(WINDOW_CYCLES - 1);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [PIO_W-1:0] r_win_cnt;
   logic [PIO_W-1:0] r_pio [N_CNT];
   logic [PIO_W-1:0] r_window_id;
   logic             r_snap;
   logic [N_CNT-1:0] w_event;
   logic [PIO_W-1:0] w_acc     [N_CNT];
   logic [PIO_W-1:0] w_acc_inc [N_CNT];
   logic             w_count_en;
   logic             w_terminal;

   assign w_event = {switch_out_valid & switch_out_ready,
                     |(hog_out_valid & ~hog_out_ready),
                     hog_out_valid[LEVELS-1] & hog_out_ready[LEVELS-1],
                     hog_input_valid & ~hog_input_ready,
                     hog_input_valid & hog_input_ready};

   assign w_count_en = (r_state == ST_COUNT);
   assign w_terminal = w_count_en && (r_win_cnt == TERM_CNT);

   for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
      sat_counter32 #(.W(PIO_W)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .clear     (clear),
         .load_zero (w_terminal),
         .inc       (w_event[g] & w_count_en),
         .count     (w_acc[g]),
         .count_inc (w_acc_inc[g])
      );
   end

   // Next state: clear always parks in IDLE; enable moves between states.
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else if (r_state == ST_IDLE) begin
         if (enable) w_state_nxt = ST_COUNT;
      end else begin
         if (!enable) w_state_nxt = ST_IDLE;
      end
   end

   // State register and window position; the position is held while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_win_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (clear || w_terminal) begin
            r_win_cnt <= '0;
         end else if (w_count_en) begin
            r_win_cnt <= r_win_cnt + PIO_W'(1);
         end
      end
   end

   // Publish registers: load on the terminal cycle, strobe one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CNT; i++) r_pio[i] <= '0;
         r_window_id <= '0;
         r_snap      <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < N_CNT; i++) r_pio[i] <= '0;
         r_window_id <= '0;
         r_snap      <= 1'b0;
      end else begin
         r_snap <= w_terminal;
         if (w_terminal) begin
            for (int i = 0; i < N_CNT; i++) r_pio[i] <= w_acc_inc[i];
            r_window_id <= r_window_id + PIO_W'(1);
         end
      end
   end

   assign in_beats_pio     = r_pio[0];
   assign in_stall_pio     = r_pio[1];
   assign out_beats_pio    = r_pio[2];
   assign out_bp_pio       = r_pio[3];
   assign switch_beats_pio = r_pio[4];
   assign window_id_pio    = r_window_id;
   assign snap_pulse       = r_snap;
   assign dbg_state        = r_state;

endmodule
